bw_io_ddr_lane_rdq: RTL
=======================

// Module: bw_io_ddr_lane_rdq
// PURPOSE
//  Parametrised DDR read-capture queue for an N-lane DQ group; successor to the fixed 4-lane 6sig group.
//  Each lane pushes strobe-qualified pos/neg data words, already in the rclk domain, into its own FIFO.
//  A burst FSM pops all enabled lanes in lock-step, giving lane deskew, and counts BL4/BL8 beats.
//  It also flags overflow and read timeout. Sits between the per-lane DDR pads and the DRAM controller read path.
// PARAMETERS
//  NLANES   4    number of DQ lanes (1..8)
//  DQ_W     4    DQ bits per lane
//  DEPTH    4    per-lane FIFO entries (power of 2, >=2)
//  TMO_CYC  64   rclk cycles without a pop in BURST before timeout (>=2)
// PORTS
//  rclk             in   1             core clock, all logic rising-edge
//  rst              in   1             synchronous reset, active-high
//  lane_en          in   NLANES        lane enable; change only in IDLE
//  lane_vld         in   NLANES        per-lane capture strobe (1 beat = pos+neg word)
//  lane_data_pos    in   NLANES*DQ_W   rising-edge data, lane i at [i*DQ_W +: DQ_W]
//  lane_data_neg    in   NLANES*DQ_W   falling-edge data, same packing
//  burst_length_four in  1             1: BL4 (2 beats), 0: BL8 (4 beats); sampled at rd_start
//  rd_start         in   1             one-cycle pulse: expect one burst
//  out_vld          out  1             aligned beat valid (registered)
//  out_data_pos     out  NLANES*DQ_W   aligned pos data; disabled lanes drive 0
//  out_data_neg     out  NLANES*DQ_W   aligned neg data; disabled lanes drive 0
//  burst_done       out  1             one-cycle pulse with the last beat of a burst
//  rd_timeout       out  1             one-cycle pulse on timeout
//  lane_ovf         out  NLANES        sticky per-lane overflow; cleared only by rst
//  busy             out  1             FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FIFOs empty, FSM=IDLE, beat and timeout counters 0.
//  Push: lane i writes when lane_vld[i] & lane_en[i] & (!full[i] | pop).
//   - Full with no same-cycle pop: word dropped, lane_ovf[i] set.
//   - Pushes are accepted in any state, so early data before rd_start is kept.
//  Pop: pop = (state==BURST) & (all enabled lanes non-empty); all enabled lanes pop together.
//  Output: out_* registered from the FIFO heads; out_vld=1 the cycle after pop.
//   - Min latency: push at cycle t -> out_vld at t+1 (empty FIFO, BURST already active).
//   - out_data holds its last value when out_vld=0.
//  Push and pop on the same lane in the same cycle: both occur and the count is unchanged (also when full).
//  FSM:
//   IDLE : rd_start & |lane_en -> BURST. Load beats = burst_length_four ? 2 : 4; clear timeout counter.
//          rd_start with lane_en==0 is ignored.
//   BURST: on each pop, decrement beats and clear the timeout counter.
//          Pop with beats==1 -> IDLE, with burst_done asserted in the same cycle as that beat's out_vld.
//          No pop for TMO_CYC consecutive cycles -> FLUSH, rd_timeout pulse.
//          rd_start in BURST is ignored (no queueing).
//   FLUSH: one cycle; all FIFOs reset to empty; lane_ovf untouched -> IDLE.
//          Pushes in the FLUSH cycle are discarded.
//  rst in any state, including mid-burst: immediate return to reset values next edge.
//  Pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSB differs & low bits equal.
//  Beat counter is 3 bits. Timeout counter is $clog2(TMO_CYC+1) bits and saturates.
// CONFIGURATION
//  DDR_LANE_ERRCNT_EN defined: adds output err_cnt[7:0].
//   - Increments by 1 per cycle with any drop or rd_timeout, saturating at 8'hFF; cleared by rst.
//  DDR_LANE_ERRCNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  T1 NLANES=4, BL4: rd_start, then all lanes vld 2 cycles with pos=i, neg=~i
//     -> out_vld 2 cycles, data matches per lane, burst_done with beat 2, busy falls next cycle.
//  T2 Skew: lane0 pushes at t, lane3 at t+3 for BL8
//     -> first out_vld at t+4; 4 aligned beats in push order; no ovf.
//  T3 lane_en=4'b0101, BL8 -> lanes 1/3 out data=0, lane_vld[1] ignored, 4 beats, burst_done.
//  T4 DEPTH=4, lane2 pushes 5 beats in IDLE
//     -> lane_ovf=4'b0100, later burst returns first 4 words; err_cnt=1 with macro.
//  T5 BURST with lane1 never valid, TMO_CYC=64
//     -> rd_timeout pulse 64 cycles after the last pop/entry, FIFOs empty, busy=0, no burst_done.
//  T6 rst asserted mid-BL8 after 2 beats -> all outputs 0 next cycle; new BL4 burst then completes normally.

Source files
------------

// File: rtl/bw_io_ddr_lane_rdq.sv
// DDR read-capture queue: per-lane FIFOs popped in lock-step by a BL4/BL8 burst FSM.
// Optional feature macro: DDR_LANE_ERRCNT_EN adds a saturating drop/timeout counter err_cnt.
module bw_io_ddr_lane_rdq #(
  parameter int unsigned NLANES  = 4,
  parameter int unsigned DQ_W    = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TMO_CYC = 64
) (
  input  logic                     rclk,
  input  logic                     rst,
  input  logic [NLANES-1:0]        lane_en,
  input  logic [NLANES-1:0]        lane_vld,
  input  logic [NLANES*DQ_W-1:0]   lane_data_pos,
  input  logic [NLANES*DQ_W-1:0]   lane_data_neg,
  input  logic                     burst_length_four,
  input  logic                     rd_start,
  output logic                     out_vld,
  output logic [NLANES*DQ_W-1:0]   out_data_pos,
  output logic [NLANES*DQ_W-1:0]   out_data_neg,
  output logic                     burst_done,
  output logic                     rd_timeout,
  output logic [NLANES-1:0]        lane_ovf,
`ifdef DDR_LANE_ERRCNT_EN
  output logic [7:0]               err_cnt,
`endif
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TMO_CYC + 1);
  localparam int unsigned DW = NLANES * DQ_W;

  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_e;

  state_e                    state_q, state_d;
  logic [2:0]                beats_q, beats_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [NLANES-1:0][PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2*DQ_W-1:0]         mem_q [NLANES][DEPTH];
  logic                      out_vld_q, burst_done_q, rd_timeout_q, busy_q;
  logic [DW-1:0]             out_pos_q, out_neg_q, head_pos_c, head_neg_c;
  logic [NLANES-1:0]         lane_ovf_q;
  logic [NLANES-1:0]         full_c, empty_c, push_c, drop_c;
  logic                      pop_c, flush_c, tmo_fire_c, done_c;

  // FIFO status, lock-step pop, push/drop qualification and aligned head data
  always_comb begin
    full_c     = '0;
    empty_c    = '0;
    push_c     = '0;
    drop_c     = '0;
    head_pos_c = '0;
    head_neg_c = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      empty_c[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full_c[i]  = (wr_ptr_q[i][PW-1] != rd_ptr_q[i][PW-1]) &&
                   (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    end
    pop_c = (state_q == BURST) && ((empty_c & lane_en) == '0);
    for (int unsigned i = 0; i < NLANES; i++) begin
      push_c[i] = lane_vld[i] && lane_en[i] && (!full_c[i] || pop_c) && (state_q != FLUSH);
      drop_c[i] = lane_vld[i] && lane_en[i] && full_c[i] && !pop_c && (state_q != FLUSH);
      if (lane_en[i]) begin
        head_pos_c[i*DQ_W +: DQ_W] = mem_q[i][rd_ptr_q[i][AW-1:0]][2*DQ_W-1:DQ_W];
        head_neg_c[i*DQ_W +: DQ_W] = mem_q[i][rd_ptr_q[i][AW-1:0]][DQ_W-1:0];
      end
    end
  end

  // Burst FSM next-state and strobes
  always_comb begin
    state_d    = state_q;
    beats_d    = beats_q;
    tmo_d      = tmo_q;
    tmo_fire_c = 1'b0;
    flush_c    = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_start && (|lane_en)) begin
          state_d = BURST;
          beats_d = burst_length_four ? 3'd2 : 3'd4;
          tmo_d   = '0;
        end
      end
      BURST: begin
        if (pop_c) begin
          beats_d = beats_q - 3'd1;
          tmo_d   = '0;
          if (beats_q == 3'd1) begin
            state_d = IDLE;
            done_c  = 1'b1;
          end
        end else if (tmo_q >= TW'(TMO_CYC - 1)) begin
          state_d    = FLUSH;
          tmo_fire_c = 1'b1;
        end else begin
          tmo_d = (&tmo_q) ? tmo_q : tmo_q + TW'(1);
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q      <= IDLE;
      beats_q      <= '0;
      tmo_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_vld_q    <= 1'b0;
      out_pos_q    <= '0;
      out_neg_q    <= '0;
      burst_done_q <= 1'b0;
      rd_timeout_q <= 1'b0;
      lane_ovf_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      tmo_q        <= tmo_d;
      out_vld_q    <= pop_c;
      burst_done_q <= done_c;
      rd_timeout_q <= tmo_fire_c;
      lane_ovf_q   <= lane_ovf_q | drop_c;
      busy_q       <= (state_d != IDLE);
      if (pop_c) begin
        out_pos_q <= head_pos_c;
        out_neg_q <= head_neg_c;
      end
      for (int unsigned i = 0; i < NLANES; i++) begin
        if (flush_c) begin
          wr_ptr_q[i] <= '0;
          rd_ptr_q[i] <= '0;
        end else begin
          if (push_c[i])            wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
          if (pop_c && lane_en[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        end
      end
    end
  end

  // Storage needs no reset; pointers define validity
  always_ff @(posedge rclk) begin
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (push_c[i]) begin
        mem_q[i][wr_ptr_q[i][AW-1:0]] <= {lane_data_pos[i*DQ_W +: DQ_W],
                                          lane_data_neg[i*DQ_W +: DQ_W]};
      end
    end
  end

`ifdef DDR_LANE_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge rclk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (((|drop_c) || tmo_fire_c) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign out_vld      = out_vld_q;
  assign out_data_pos = out_pos_q;
  assign out_data_neg = out_neg_q;
  assign burst_done   = burst_done_q;
  assign rd_timeout   = rd_timeout_q;
  assign lane_ovf     = lane_ovf_q;
  assign busy         = busy_q;

endmodule
